// File: rtl/dac_serializer_pkg.sv
// Shared types and constants for the SPI DAC frame serializer.
package dac_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam logic [3:0] CFG_BITS_DEFAULT = 4'b0011;
    localparam int CLK_DIV_MIN = 1;
    localparam int CLK_DIV_MAX = 255;

    function automatic bit clk_div_legal(input int div);
        return (div >= CLK_DIV_MIN) && (div <= CLK_DIV_MAX);
    endfunction

    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [3:0] cfg,
                                                         input logic [7:0] sample);
        return {cfg, sample, 4'b0000};
    endfunction

endpackage

// File: rtl/dac_serializer_sclk_phase_ctr.sv
// Half-period timer: counts 0..CLK_DIV-1 and flags the final cycle of each phase.
module sclk_phase_ctr #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic phase_end
);

    logic [7:0] cnt;

    assign phase_end = (cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || phase_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/dac_serializer.sv
// Shifts each 8-bit sample to an SPI DAC as a 16-bit frame, with a
// single-entry pending buffer and a sticky overrun flag.
module dac_serializer
    import dac_serializer_pkg::*;
#(
    parameter int         CLK_DIV  = 4,
    parameter logic [3:0] CFG_BITS = CFG_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  sample_in,
    input  logic        sample_valid,
    input  logic        overrun_clr,
    output logic        dac_cs_n,
    output logic        dac_sclk,
    output logic        dac_din,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] frames_sent
);

    if (!clk_div_legal(CLK_DIV)) begin : g_bad_clk_div
        $error("dac_serializer: CLK_DIV must be in 1..255");
    end

    state_t                state, state_nxt;
    logic [FRAME_BITS-1:0] shreg, shreg_nxt, word;
    logic [3:0]            bit_cnt, bit_cnt_nxt;
    logic [7:0]            pend_data, pend_data_nxt, start_sample;
    logic                  pend_full, pend_full_nxt;
    logic                  cs_nxt, sclk_nxt, din_nxt, busy_nxt, overrun_nxt;
    logic [15:0]           frames_nxt;
    logic                  start, absorb, overrun_set;
    logic                  restart, phase_end;

    assign restart = (state_nxt != state) || (state == ST_IDLE);

    sclk_phase_ctr #(.CLK_DIV(CLK_DIV)) u_phase (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (restart),
        .phase_end (phase_end)
    );

    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        bit_cnt_nxt   = bit_cnt;
        pend_data_nxt = pend_data;
        pend_full_nxt = pend_full;
        cs_nxt        = dac_cs_n;
        sclk_nxt      = dac_sclk;
        din_nxt       = dac_din;
        frames_nxt    = frames_sent;
        start         = 1'b0;
        absorb        = 1'b0;
        overrun_set   = 1'b0;
        start_sample  = sample_in;
        word          = '0;

        case (state)
            ST_IDLE: begin
                if (pend_full) begin
                    start        = 1'b1;
                    start_sample = pend_data;
                    absorb       = 1'b1;
                    pend_full_nxt = 1'b0;
                end else if (sample_valid) begin
                    start = 1'b1;
                end
            end
            ST_SETUP: begin
                absorb = 1'b1;
                if (phase_end) begin
                    state_nxt = ST_SHIFT;
                    sclk_nxt  = 1'b1;
                end
            end
            ST_SHIFT: begin
                absorb = 1'b1;
                if (phase_end) begin
                    // Data moves on the falling edge so it is settled for the DAC's rising-edge sample.
                    if (dac_sclk) begin
                        sclk_nxt  = 1'b0;
                        shreg_nxt = shreg << 1;
                        din_nxt   = shreg[FRAME_BITS-2];
                    end else if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                        state_nxt = ST_GAP;
                        cs_nxt    = 1'b1;
                        din_nxt   = 1'b0;
                    end else begin
                        sclk_nxt    = 1'b1;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end
                end
            end
            ST_GAP: begin
                if (phase_end) begin
                    frames_nxt = frames_sent + 16'd1;
                    if (pend_full) begin
                        start         = 1'b1;
                        start_sample  = pend_data;
                        absorb        = 1'b1;
                        pend_full_nxt = 1'b0;
                    end else if (sample_valid) begin
                        start = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    absorb = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // A handed-off pending slot counts as empty, so a same-cycle sample refills it without overrun.
        if (absorb && sample_valid) begin
            overrun_set   = pend_full_nxt;
            pend_full_nxt = 1'b1;
            pend_data_nxt = sample_in;
        end

        if (start) begin
            word        = frame_word(CFG_BITS, start_sample);
            state_nxt   = ST_SETUP;
            shreg_nxt   = word;
            bit_cnt_nxt = '0;
            cs_nxt      = 1'b0;
            sclk_nxt    = 1'b0;
            din_nxt     = word[FRAME_BITS-1];
        end

        overrun_nxt = overrun_set | (overrun & ~overrun_clr);
        busy_nxt    = (state_nxt != ST_IDLE) | pend_full_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            pend_data   <= '0;
            pend_full   <= 1'b0;
            dac_cs_n    <= 1'b1;
            dac_sclk    <= 1'b0;
            dac_din     <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            frames_sent <= '0;
        end else begin
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            bit_cnt     <= bit_cnt_nxt;
            pend_data   <= pend_data_nxt;
            pend_full   <= pend_full_nxt;
            dac_cs_n    <= cs_nxt;
            dac_sclk    <= sclk_nxt;
            dac_din     <= din_nxt;
            busy        <= busy_nxt;
            overrun     <= overrun_nxt;
            frames_sent <= frames_nxt;
        end
    end

endmodule

// File: tb/tb_dac_serializer.sv
// Scoreboard bench: two serializer instances (CLK_DIV 4 and 1) with a frame-decoding monitor.
module tb_dac_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       overrun_clr = 1'b0;
    logic [7:0] sample_in = '0;
    logic       vld4 = 1'b0, vld1 = 1'b0;

    logic        cs4, sclk4, din4, busy4, ovr4;
    logic        cs1, sclk1, din1, busy1, ovr1;
    logic [15:0] fs4, fs1;

    dac_serializer #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(vld4),
        .overrun_clr(overrun_clr), .dac_cs_n(cs4), .dac_sclk(sclk4), .dac_din(din4),
        .busy(busy4), .overrun(ovr4), .frames_sent(fs4)
    );

    dac_serializer #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(vld1),
        .overrun_clr(overrun_clr), .dac_cs_n(cs1), .dac_sclk(sclk1), .dac_din(din1),
        .busy(busy1), .overrun(ovr1), .frames_sent(fs1)
    );

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    int gap_len[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Frame monitor: decodes each cs_n-low window and checks SCLK/DIN timing
    bit          prev_cs[2] = '{1'b1, 1'b1};
    bit          prev_sc[2], prev_d[2], in_frame[2], tbad[2];
    int          nbits[2], low_cnt[2], run[2], dstab[2], hi_cnt[2];
    logic [15:0] word[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic        cs, sc, d, got;
            int          div;
            logic [15:0] want;
            cs   = (i == 0) ? cs4 : cs1;
            sc   = (i == 0) ? sclk4 : sclk1;
            d    = (i == 0) ? din4 : din1;
            div  = (i == 0) ? 4 : 1;
            got  = 1'b0;
            want = '0;
            if (!rst_n) begin
                in_frame[i] = 1'b0;
                hi_cnt[i]   = 0;
            end else if (prev_cs[i] && !cs) begin
                in_frame[i] = 1'b1;
                nbits[i] = 0; word[i] = '0; low_cnt[i] = 1; run[i] = 1; dstab[i] = 1;
                tbad[i] = 1'b0;
                gap_len[i] = hi_cnt[i];
            end else if (in_frame[i] && !cs) begin
                low_cnt[i]++;
                if (d == prev_d[i]) dstab[i]++; else dstab[i] = 1;
                if (sc == prev_sc[i]) run[i]++;
                else begin
                    if (run[i] != div) tbad[i] = 1'b1;
                    run[i] = 1;
                end
                if (sc && !prev_sc[i]) begin
                    word[i] = {word[i][14:0], d};
                    nbits[i]++;
                    if (dstab[i] < div + 1) tbad[i] = 1'b1;
                end
            end else if (in_frame[i] && cs) begin
                in_frame[i] = 1'b0;
                hi_cnt[i] = 1;
                if (run[i] != div) tbad[i] = 1'b1;
                if (i == 0 && exp_q0.size() > 0) begin want = exp_q0.pop_front(); got = 1'b1; end
                if (i == 1 && exp_q1.size() > 0) begin want = exp_q1.pop_front(); got = 1'b1; end
                if (got) check($sformatf("frame_word[%0d]", i), word[i], want);
                else begin
                    total++; bad++;
                    $display("FAIL frame_unexpected[%0d]: got 0x%0h want none", i, word[i]);
                end
                check($sformatf("frame_bits[%0d]", i), nbits[i], 16);
                check($sformatf("cs_low_cycles[%0d]", i), low_cnt[i], 33 * div);
                check($sformatf("sclk_din_timing[%0d]", i), tbad[i], 0);
            end else if (cs) begin
                hi_cnt[i]++;
            end
            prev_cs[i] = cs;
            prev_sc[i] = sc;
            prev_d[i]  = d;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int idx, input logic [7:0] s, input logic clr);
        sample_in   = s;
        overrun_clr = clr;
        if (idx == 0) vld4 = 1'b1; else vld1 = 1'b1;
        @(posedge clk);
        #1;
        vld4 = 1'b0;
        vld1 = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic wait_frames(input int idx, input logic [15:0] target, input int budget);
        int n = 0;
        while (((idx == 0) ? fs4 : fs1) != target && n < budget) begin
            cycles(1);
            n++;
        end
        check("frames_sent_wait", (idx == 0) ? fs4 : fs1, target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(3);
        check("rst_cs_n", cs4, 1);
        check("rst_sclk", sclk4, 0);
        check("rst_din", din4, 0);
        check("rst_busy", busy4, 0);
        check("rst_overrun", ovr4, 0);
        check("rst_frames", fs4, 0);
        check("rst_cs_n_div1", cs1, 1);
        rst_n = 1'b1;
        cycles(1);

        // Single frame, latency and completion
        exp_q0.push_back(16'h3A50);
        strobe(0, 8'hA5, 1'b0);
        check("t1_cs_fall", cs4, 0);
        check("t1_busy", busy4, 1);
        cycles(131);
        check("t1_cs_still_low", cs4, 0);
        cycles(1);
        check("t1_cs_rise", cs4, 1);
        cycles(3);
        check("t1_frames_before", fs4, 0);
        check("t1_busy_gap", busy4, 1);
        cycles(1);
        check("t1_frames_after", fs4, 1);
        check("t1_busy_end", busy4, 0);

        // CLK_DIV=1: 34-cycle frame
        exp_q1.push_back(16'h3C30);
        strobe(1, 8'hC3, 1'b0);
        cycles(33);
        check("t2_div1_frames_before", fs1, 0);
        cycles(1);
        check("t2_div1_frames_after", fs1, 1);
        check("t2_div1_busy", busy1, 0);

        // Back-to-back via pending register
        exp_q0.push_back(16'h3110);
        exp_q0.push_back(16'h3220);
        strobe(0, 8'h11, 1'b0);
        cycles(20);
        strobe(0, 8'h22, 1'b0);
        check("t3_busy", busy4, 1);
        check("t3_overrun", ovr4, 0);
        wait_frames(0, 16'd3, 400);
        check("t3_gap_len", gap_len[0], 4);
        check("t3_overrun_end", ovr4, 0);

        // Overwrite, sticky overrun, clear, set-wins
        exp_q0.push_back(16'h3110);
        exp_q0.push_back(16'h3330);
        strobe(0, 8'h11, 1'b0);
        cycles(10);
        strobe(0, 8'h22, 1'b0);
        check("t4_no_overrun_yet", ovr4, 0);
        cycles(10);
        strobe(0, 8'h33, 1'b0);
        check("t4_overrun_set", ovr4, 1);
        wait_frames(0, 16'd5, 400);
        check("t4_overrun_sticky", ovr4, 1);
        overrun_clr = 1'b1;
        cycles(1);
        overrun_clr = 1'b0;
        check("t4_overrun_clr", ovr4, 0);
        exp_q0.push_back(16'h3440);
        exp_q0.push_back(16'h3660);
        strobe(0, 8'h44, 1'b0);
        cycles(10);
        strobe(0, 8'h55, 1'b0);
        cycles(5);
        strobe(0, 8'h66, 1'b1);
        check("t4_set_wins", ovr4, 1);
        wait_frames(0, 16'd7, 400);
        check("t4_set_wins_sticky", ovr4, 1);

        // Reset mid-SHIFT (bit 7)
        strobe(0, 8'hC3, 1'b0);
        cycles(62);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_cs_n", cs4, 1);
        check("t5_sclk", sclk4, 0);
        check("t5_busy", busy4, 0);
        check("t5_frames", fs4, 0);
        check("t5_overrun", ovr4, 0);
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        exp_q0.push_back(16'h35A0);
        strobe(0, 8'h5A, 1'b0);
        wait_frames(0, 16'd1, 400);
        check("t5_busy_end", busy4, 0);

        // frames_sent wrap
        force dut4.frames_sent = 16'hFFFF;
        cycles(2);
        release dut4.frames_sent;
        cycles(1);
        check("t6_preload", fs4, 16'hFFFF);
        exp_q0.push_back(16'h3010);
        strobe(0, 8'h01, 1'b0);
        wait_frames(0, 16'h0000, 400);
        check("t6_busy_end", busy4, 0);

        cycles(5);
        check("q0_left", exp_q0.size(), 0);
        check("q1_left", exp_q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
